// File: rtl/hazard_forward_unit.sv
// Purpose: issue-side hazard/forwarding scoreboard between decode and execute; tracks in-flight rd's and tags each source operand.
// Latency: issue to ex_* and src_tag is 1 cycle; stall_out is combinational from inputs and current state.
// Backpressure: stall_out holds decode on execute hold, load-use hazard or unresolved branch; downstream entries always drain.
module hazard_forward_unit #(
  parameter int D        = 3,
  parameter int NUM_SRC  = 2,
  parameter int NUM_BUF  = 1,
  parameter int LOAD_LAT = 1,
  localparam int TAG_W   = $clog2(D + NUM_BUF + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [NUM_SRC*5-1:0]     issue_rs,
  input  logic [NUM_SRC-1:0]       issue_rs_used,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_writes_rd,
  input  logic                     issue_is_load,
  input  logic                     issue_is_branch,
  input  logic                     stall_in,
  input  logic                     branch_resolve,
  output logic                     stall_out,
  output logic                     ex_valid,
  output logic [4:0]               ex_rd,
  output logic                     ex_writes_rd,
  output logic                     ex_is_load,
  output logic [NUM_SRC*TAG_W-1:0] src_tag,
  output logic                     branch_pending
);

  // Highest tag value: the last forwarding buffer. Aging past it means the
  // value has been retired to the register file.
  localparam logic [TAG_W-1:0] TAG_MAX = TAG_W'(D + NUM_BUF);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state;

  // Pipeline tracking entries; entry 0 is the ID/EX register.
  logic       ent_vld [D];
  logic [4:0] ent_rd  [D];
  logic       ent_wr  [D];
  logic       ent_ld  [D];

  // An entry can supply a value only if it is real, writes, and is not x0.
  logic [D-1:0] ent_live;

  logic [TAG_W-1:0]   tag_c [NUM_SRC];
  logic [NUM_SRC-1:0] lu_c;
  logic               load_use;
  logic               accept;

  // Qualify each entry as a possible forwarding producer.
  always_comb begin
    ent_live = '0;
    for (int k = 0; k < D; k++) begin
      ent_live[k] = ent_vld[k] && ent_wr[k] && (ent_rd[k] != 5'd0);
    end
  end

  // Per-operand tag lookup. Scan from the oldest entry down so the nearest
  // (lowest index) producer overwrites any older match.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      tag_c[i] = '0;
      lu_c[i]  = 1'b0;
      if (issue_rs_used[i] && (issue_rs[5*i +: 5] != 5'd0)) begin
        for (int k = D - 1; k >= 0; k--) begin
          if (ent_live[k] && (ent_rd[k] == issue_rs[5*i +: 5])) begin
            tag_c[i] = TAG_W'(k + 1);
            lu_c[i]  = ent_ld[k] && (k < LOAD_LAT);
          end
        end
      end
    end
  end

  // Issue gating: any hold condition refuses the presented instruction.
  always_comb begin
    load_use  = |lu_c;
    stall_out = issue_valid && (stall_in || load_use || branch_pending);
    accept    = issue_valid && !stall_out;
  end

  // Entry shift register. Under stall_in the ID/EX entry freezes and a
  // bubble enters behind it while the older stages keep draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        ent_vld[k] <= 1'b0;
        ent_rd[k]  <= 5'd0;
        ent_wr[k]  <= 1'b0;
        ent_ld[k]  <= 1'b0;
      end
    end else if (!stall_in) begin
      for (int k = 1; k < D; k++) begin
        ent_vld[k] <= ent_vld[k-1];
        ent_rd[k]  <= ent_rd[k-1];
        ent_wr[k]  <= ent_wr[k-1];
        ent_ld[k]  <= ent_ld[k-1];
      end
      if (accept) begin
        ent_vld[0] <= 1'b1;
        ent_rd[0]  <= issue_rd;
        ent_wr[0]  <= issue_writes_rd;
        ent_ld[0]  <= issue_is_load;
      end else begin
        ent_vld[0] <= 1'b0;
        ent_rd[0]  <= 5'd0;
        ent_wr[0]  <= 1'b0;
        ent_ld[0]  <= 1'b0;
      end
    end else begin
      for (int k = 1; k < D; k++) begin
        if (k == 1) begin
          ent_vld[k] <= 1'b0;
          ent_rd[k]  <= 5'd0;
          ent_wr[k]  <= 1'b0;
          ent_ld[k]  <= 1'b0;
        end else begin
          ent_vld[k] <= ent_vld[k-1];
          ent_rd[k]  <= ent_rd[k-1];
          ent_wr[k]  <= ent_wr[k-1];
          ent_ld[k]  <= ent_ld[k-1];
        end
      end
    end
  end

  // Source tags: load on accept; while execute is held the producers move
  // one stage further each cycle, so every live tag advances with them.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_tag <= '0;
    end else if (stall_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_tag[i*TAG_W +: TAG_W] == '0) begin
          src_tag[i*TAG_W +: TAG_W] <= '0;
        end else if (src_tag[i*TAG_W +: TAG_W] < TAG_MAX) begin
          src_tag[i*TAG_W +: TAG_W] <= src_tag[i*TAG_W +: TAG_W] + 1'b1;
        end else begin
          src_tag[i*TAG_W +: TAG_W] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_tag[i*TAG_W +: TAG_W] <= tag_c[i];
      end
    end
  end

  // Branch FSM: an accepted branch blocks issue until execute resolves it.
  // A resolve with no branch outstanding has nothing to clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      branch_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && issue_is_branch) begin
            state          <= S_WAIT;
            branch_pending <= 1'b1;
          end
        end
        S_WAIT: begin
          if (branch_resolve) begin
            state          <= S_IDLE;
            branch_pending <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          branch_pending <= 1'b0;
        end
      endcase
    end
  end

  // Execute-stage view is simply the ID/EX entry.
  assign ex_valid     = ent_vld[0];
  assign ex_rd        = ent_rd[0];
  assign ex_writes_rd = ent_wr[0];
  assign ex_is_load   = ent_ld[0];

endmodule
